// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin register-file write arbiter
module regfile_write_arbiter #(
  parameter int N    = 64,
  parameter int REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            req0_valid,
  input  logic [4:0]      req0_addr,
  input  logic [N-1:0]    req0_data,
  input  logic            req1_valid,
  input  logic [4:0]      req1_addr,
  input  logic [N-1:0]    req1_data,
  output logic            req0_ready,
  output logic            req1_ready,
  output logic [REGS-1:0] wr_load,
  output logic [4:0]      wr_addr,
  output logic [N-1:0]    wr_data,
  output logic            wr_valid,
  output logic [7:0]      x0_drops
);

  // 1 means requester 1 won most recently, so requester 0 wins the next tie
  logic            r_last_grant;
  logic            r_wr_valid;
  logic [4:0]      r_wr_addr;
  logic [N-1:0]    r_wr_data;
  logic [REGS-1:0] r_wr_load;
  logic [7:0]      r_x0_drops;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_fire;
  logic [4:0]      w_addr;
  logic [N-1:0]    w_data;
  logic [REGS-1:0] w_onehot;

  // Grant selection: nothing while held in reset or stalled, round-robin on contention
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset && !stall) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign w_fire   = w_grant0 | w_grant1;
  assign w_addr   = w_grant1 ? req1_addr : req0_addr;
  assign w_data   = w_grant1 ? req1_data : req0_data;
  assign w_onehot = {{(REGS-1){1'b0}}, 1'b1} << w_addr;

  // Register the accepted write one cycle; x0 writes are committed but never loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_load    <= '0;
      r_x0_drops   <= '0;
    end else begin
      r_wr_valid <= w_fire;
      r_wr_load  <= (w_fire && (w_addr != 5'd0)) ? w_onehot : '0;
      if (w_fire) begin
        r_last_grant <= w_grant1;
        r_wr_addr    <= w_addr;
        r_wr_data    <= w_data;
        if ((w_addr == 5'd0) && (r_x0_drops != 8'hFF)) begin
          r_x0_drops <= r_x0_drops + 8'd1;
        end
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_load    = r_wr_load;
  assign x0_drops   = r_x0_drops;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int N    = 64;
  localparam int REGS = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            req0_valid;
  logic [4:0]      req0_addr;
  logic [N-1:0]    req0_data;
  logic            req1_valid;
  logic [4:0]      req1_addr;
  logic [N-1:0]    req1_data;
  logic            req0_ready;
  logic            req1_ready;
  logic [REGS-1:0] wr_load;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            wr_valid;
  logic [7:0]      x0_drops;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.N(N), .REGS(REGS)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .wr_load    (wr_load),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .x0_drops   (x0_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the arbiter
  int          m_last     = 1;
  bit          m_wr_valid = 0;
  int          m_wr_addr  = 0;
  logic [63:0] m_wr_data  = '0;
  int          m_drops    = 0;

  function automatic int model_grant();
    if (reset !== 1'b1 || stall) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(negedge reset) begin
    m_last     = 1;
    m_wr_valid = 0;
    m_wr_addr  = 0;
    m_wr_data  = '0;
    m_drops    = 0;
  end

  always @(posedge clk) begin
    int g;
    if (reset === 1'b1) begin
      g = model_grant();
      m_wr_valid = (g >= 0);
      if (g >= 0) begin
        m_last    = g;
        m_wr_addr = (g == 0) ? int'(req0_addr) : int'(req1_addr);
        m_wr_data = (g == 0) ? req0_data : req1_data;
        if (m_wr_addr == 0 && m_drops < 255) m_drops = m_drops + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int g;
    logic [63:0] exp_load;
    g = model_grant();
    exp_load = (m_wr_valid && m_wr_addr != 0) ? (64'd1 << m_wr_addr) : 64'd0;
    chk("cmp_ready0", 64'(req0_ready), 64'(g == 0));
    chk("cmp_ready1", 64'(req1_ready), 64'(g == 1));
    chk("cmp_wr_valid", 64'(wr_valid), 64'(m_wr_valid));
    chk("cmp_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    chk("cmp_wr_data", wr_data, m_wr_data);
    chk("cmp_wr_load", 64'(wr_load), exp_load);
    chk("cmp_x0_drops", 64'(x0_drops), 64'(m_drops));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    cyc();
    cyc();
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_load", 64'(wr_load), 64'd0);
    chk("rst_x0_drops", 64'(x0_drops), 64'd0);
    reset = 1'b1;

    // single request from the ALU path
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA5;
    #1 chk("t1_ready0", 64'(req0_ready), 64'd1);
    cyc();
    chk("t1_wr_load", 64'(wr_load), 64'h20);
    chk("t1_wr_data", wr_data, 64'hA5);
    chk("t1_wr_valid", 64'(wr_valid), 64'd1);
    req0_valid = 1'b0;

    // single req1 write so requester 0 wins the next contention
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h2;
    cyc();
    req1_valid = 1'b0;

    // four cycles of contention: grants 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h33;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h77;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      cyc();
      chk("rr_wr_load", 64'(wr_load), (i % 2 == 0) ? 64'h08 : 64'h80);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // writes to x0 are dropped and counted, saturating at 255
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("x0_wr_load", 64'(wr_load), 64'd0);
      chk("x0_wr_valid", 64'(wr_valid), 64'd1);
    end
    chk("x0_drops_3", 64'(x0_drops), 64'd3);
    for (int i = 0; i < 297; i++) cyc();
    chk("x0_drops_sat", 64'(x0_drops), 64'd255);
    req1_valid = 1'b0;

    // stall blocks both requesters; last grant was 1 so req0 wins afterwards
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 64'h1010;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 64'h1212;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready0", 64'(req0_ready), 64'd0);
      chk("stall_ready1", 64'(req1_ready), 64'd0);
      cyc();
      chk("stall_wr_load", 64'(wr_load), 64'd0);
    end
    stall = 1'b0;
    #1 chk("unstall_ready0", 64'(req0_ready), 64'd1);
    chk("unstall_ready1", 64'(req1_ready), 64'd0);
    cyc();
    chk("unstall_wr_load", 64'(wr_load), 64'h400);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // same-address contention: last grant was 0, so req1 goes first
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h11;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 64'h22;
    #1 chk("same_ready1", 64'(req1_ready), 64'd1);
    cyc();
    chk("same_load_a", 64'(wr_load), 64'h200);
    chk("same_data_a", wr_data, 64'h22);
    req1_valid = 1'b0;
    #1 chk("same_ready0", 64'(req0_ready), 64'd1);
    cyc();
    chk("same_load_b", 64'(wr_load), 64'h200);
    chk("same_data_b", wr_data, 64'h11);
    req0_valid = 1'b0;
    cyc();
    chk("idle_wr_valid", 64'(wr_valid), 64'd0);
    chk("idle_wr_data", wr_data, 64'h11);

    // asynchronous reset right after a handshake kills the pending load
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 64'h44;
    cyc();
    req0_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("arst_wr_valid", 64'(wr_valid), 64'd0);
    chk("arst_wr_load", 64'(wr_load), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_wr_data", wr_data, 64'd0);
    chk("arst_x0_drops", 64'(x0_drops), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("arst_ready0", 64'(req0_ready), 64'd0);
    chk("arst_ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    chk("arst_no_pulse", 64'(wr_load), 64'd0);
    cyc();
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h3;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h7;
    #1 chk("post_rst_ready0", 64'(req0_ready), 64'd1);
    chk("post_rst_ready1", 64'(req1_ready), 64'd0);
    cyc();
    chk("post_rst_wr_load", 64'(wr_load), 64'h08);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter N SHALL have default 64 and set the data width of every data port.
REQ-002 Parameter REGS SHALL have default 32 and set the number of architectural registers, addressed by 5-bit indices.
REQ-003 Port clk SHALL be a 1-bit input: the single clock, with all state updating on its rising edge.
REQ-004 Port reset SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-005 Port stall SHALL be a 1-bit input: pipeline hold, which blocks all acceptance while 1.
REQ-006 Ports req0_valid and req1_valid SHALL be 1-bit inputs: write requests from the ALU writeback path (0) and the memory-load writeback path (1).
REQ-007 Ports req0_addr and req1_addr SHALL be 5-bit inputs: destination register index.
REQ-008 Ports req0_data and req1_data SHALL be N-bit inputs: write data.
REQ-009 Ports req0_ready and req1_ready SHALL be 1-bit outputs: the request is accepted this cycle.
REQ-010 Port wr_load SHALL be a REGS-bit output: one-hot load enables to the register array.
REQ-011 Port wr_addr SHALL be a 5-bit output: the index being written.
REQ-012 Port wr_data SHALL be an N-bit output: data driven to the data_in of every register.
REQ-013 Port wr_valid SHALL be a 1-bit output: wr_addr/wr_data hold a committed write this cycle (forwarding tap).
REQ-014 Port x0_drops SHALL be an 8-bit output: count of accepted writes to register 0.

Function
REQ-015 A handshake on requester k SHALL occur when reqk_valid=1 and reqk_ready=1 in the same cycle.
REQ-016 reqk_ready SHALL be combinational, and SHALL be 0 whenever stall=1.
REQ-017 With stall=0 and exactly one valid request, that requester SHALL receive ready=1.
REQ-018 With stall=0 and both requests valid, ready SHALL go to the requester not named by last_grant (round-robin), and the other requester's ready SHALL be 0.
REQ-019 last_grant SHALL update to the granted requester on every handshake, and SHALL hold otherwise.
REQ-020 At most one handshake SHALL occur per cycle.
REQ-021 Output latency SHALL be 1 cycle: a handshake in cycle t sets wr_valid=1, wr_addr and wr_data to the granted values in cycle t+1.
REQ-022 In the same cycle t+1, wr_load SHALL have exactly bit[wr_addr] set.
REQ-023 With no handshake in cycle t, wr_valid and wr_load SHALL be 0 in t+1, and wr_addr and wr_data SHALL hold their previous values.
REQ-024 An accepted write to address 0 SHALL produce wr_valid=1 and wr_addr=0 but wr_load=0, so x0 is never loaded.
REQ-025 An accepted write to address 0 SHALL increment x0_drops by 1.
REQ-026 x0_drops SHALL saturate at 255 and SHALL not wrap.
REQ-027 Both requesters targeting the same address SHALL be served in consecutive cycles in round-robin order, so the later grant's data is the final register value.
REQ-028 A requester SHALL hold valid, addr and data stable until accepted; the arbiter SHALL not buffer un-granted requests.
REQ-029 When stall deasserts, arbitration SHALL resume in that same cycle using the unchanged last_grant.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force wr_valid=0, wr_load=0, wr_addr=0, wr_data=0, x0_drops=0 and last_grant=1, so requester 0 wins the first contention.
REQ-031 While reset=0, reqk_ready SHALL be 0.
REQ-032 A handshake in the cycle before reset asserts SHALL be discarded, with no load pulse emitted after reset.
REQ-033 Release of reset SHALL take effect at the first rising clk edge after reset=1, and arbitration SHALL be enabled in that cycle.

Verification
REQ-034 The bench SHALL cover: after reset, req0 valid with addr=5 and data=0xA5 -> req0_ready=1, and next cycle wr_load=0x00000020, wr_data=0xA5, wr_valid=1.
REQ-035 The bench SHALL cover: both requesters valid for 4 cycles with addrs 3 and 7 -> grants 0,1,0,1, and wr_load alternates 0x08/0x80 one cycle later.
REQ-036 The bench SHALL cover: req1 writes addr=0 three times -> wr_load stays 0 and x0_drops=3; after 300 such writes -> x0_drops=255.
REQ-037 The bench SHALL cover: stall=1 with both requests valid for 3 cycles -> both readies 0 and wr_load=0; after stall drops, the first grant follows last_grant.
REQ-038 The bench SHALL cover: reset pulsed low mid-cycle right after a handshake -> outputs zero immediately, no load pulse follows, and after release req0 wins contention.
REQ-039 The bench SHALL cover: both requesters write addr=9 (data 0x11, 0x22) -> two consecutive load pulses on bit 9, with the final wr_data equal to the later grant's data.
